// File: rtl/encoder_pkg.sv
// Shared widths and types for the registered 8-to-3 encoder.
package encoder_pkg;

    localparam int ENC_IN_W  = 8;
    localparam int ENC_OUT_W = 3;

    typedef logic [ENC_IN_W-1:0]  enc_in_t;
    typedef logic [ENC_OUT_W-1:0] enc_idx_t;

endpackage

// File: rtl/encoder_8to3_if.sv
// Request/result bundle between the select logic, the encoder stage and the index consumer.
interface encoder_8to3_if
    import encoder_pkg::*;
#(
    parameter int IN_W = ENC_IN_W
);

    localparam int OUT_W = $clog2(IN_W);

    logic [IN_W-1:0]  in;
    logic             in_valid;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic             zero;
    logic             multi;

    // Producer side: drives the candidate vector and watches the encoded result.
    modport master (
        output in,
        output in_valid,
        input  out,
        input  out_valid,
        input  zero,
        input  multi
    );

    // Encoder side: consumes the vector and presents the registered result.
    modport slave (
        input  in,
        input  in_valid,
        output out,
        output out_valid,
        output zero,
        output multi
    );

endinterface

// File: rtl/encoder_8to3_core.sv
// Combinational core: priority scan for the bit index plus a popcount-based
// detector for the empty and multi-hot cases.
module encoder_8to3_core
    import encoder_pkg::*;
#(
    parameter int  IN_W     = ENC_IN_W,
    parameter bit  PRIO_MSB = 1'b1,
    localparam int OUT_W    = $clog2(IN_W)
) (
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] idx,
    output logic             zero,
    output logic             multi
);

    localparam int CNT_W = $clog2(IN_W + 1);

    logic [CNT_W-1:0] count;

    // Priority scan: the last match in scan order wins, so the scan direction
    // selects whether the highest or the lowest set bit is reported.
    always_comb begin
        idx = '0;
        if (PRIO_MSB) begin
            for (int i = 0; i < IN_W; i++) begin
                if (in[i]) begin
                    idx = OUT_W'(i);
                end
            end
        end else begin
            for (int i = IN_W - 1; i >= 0; i--) begin
                if (in[i]) begin
                    idx = OUT_W'(i);
                end
            end
        end
    end

    // Population count drives both flags, which keeps them mutually exclusive.
    always_comb begin
        count = '0;
        for (int i = 0; i < IN_W; i++) begin
            count = count + CNT_W'(in[i]);
        end
        zero  = (count == '0);
        multi = (count >= CNT_W'(2));
    end

endmodule

// File: rtl/encoder_8to3.sv
// Registered 8-to-3 encoder stage: one cycle of latency, a new vector every
// cycle, flags qualified by in_valid.
module encoder_8to3
    import encoder_pkg::*;
#(
    parameter int  IN_W     = ENC_IN_W,
    parameter bit  PRIO_MSB = 1'b1,
    localparam int OUT_W    = $clog2(IN_W)
) (
    input  logic         clk,
    input  logic         rst,
    encoder_8to3_if.slave bus
);

    logic [OUT_W-1:0] core_idx;
    logic             core_zero;
    logic             core_multi;

    logic [OUT_W-1:0] out_q;
    logic             out_valid_q;
    logic             zero_q;
    logic             multi_q;

    encoder_8to3_core #(
        .IN_W     (IN_W),
        .PRIO_MSB (PRIO_MSB)
    ) u_core (
        .in    (bus.in),
        .idx   (core_idx),
        .zero  (core_zero),
        .multi (core_multi)
    );

    // Output register: index always follows the input, flags only count when valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            out_q       <= core_idx;
            out_valid_q <= bus.in_valid;
            zero_q      <= bus.in_valid & core_zero;
            multi_q     <= bus.in_valid & core_multi;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.zero      = zero_q;
    assign bus.multi     = multi_q;

endmodule

// File: tb/tb_encoder_8to3.sv
// Directed bench for encoder_8to3: drives an MSB-priority and an LSB-priority
// instance with the same vectors and checks hand-computed results.
module tb_encoder_8to3;
    import encoder_pkg::*;

    logic    clk;
    logic    rst;
    enc_in_t in_vec;
    logic    in_valid;

    int vectors;
    int miscompares;

    encoder_8to3_if bus_msb ();
    encoder_8to3_if bus_lsb ();

    assign bus_msb.in       = in_vec;
    assign bus_msb.in_valid = in_valid;
    assign bus_lsb.in       = in_vec;
    assign bus_lsb.in_valid = in_valid;

    // Observed results packed as {out_valid, out[2:0], zero, multi}.
    logic [5:0] obs_msb;
    logic [5:0] obs_lsb;
    assign obs_msb = {bus_msb.out_valid, bus_msb.out, bus_msb.zero, bus_msb.multi};
    assign obs_lsb = {bus_lsb.out_valid, bus_lsb.out, bus_lsb.zero, bus_lsb.multi};

    encoder_8to3 #(.PRIO_MSB(1'b1)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_msb.slave)
    );

    encoder_8to3 #(.PRIO_MSB(1'b0)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_lsb.slave)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_vec   = 8'h00;
        in_valid = 1'b0;
        #3;
        vectors++;
        if (obs_msb !== 6'b0_000_00 || obs_lsb !== 6'b0_000_00) begin
            miscompares++;
            $display("[TB] FAIL reset_initial got msb=%b lsb=%b want 000000", obs_msb, obs_lsb);
        end
        in_vec   = 8'b0000_0100;
        in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        vectors++;
        if (obs_msb !== 6'b1_010_00 || obs_lsb !== 6'b1_010_00) begin
            miscompares++;
            $display("[TB] FAIL reset_first_capture got msb=%b lsb=%b want 101000", obs_msb, obs_lsb);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (obs_msb !== 6'b0_000_00 || obs_lsb !== 6'b0_000_00) begin
            miscompares++;
            $display("[TB] FAIL reset_async got msb=%b lsb=%b want 000000", obs_msb, obs_lsb);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        vectors++;
        if (obs_msb !== 6'b0_010_00 || obs_lsb !== 6'b0_010_00) begin
            miscompares++;
            $display("[TB] FAIL reset_post_invalid got msb=%b lsb=%b want 001000", obs_msb, obs_lsb);
        end
    endtask

    task automatic test_one_hot_sweep();
        logic [2:0] want_idx;
        logic [5:0] want;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_vec   = enc_in_t'(1) << i;
            want_idx = 3'(i);
            want     = {1'b1, want_idx, 2'b00};
            tick();
            vectors++;
            if (obs_msb !== want || obs_lsb !== want) begin
                miscompares++;
                $display("[TB] FAIL one_hot_%0d got msb=%b lsb=%b want %b", i, obs_msb, obs_lsb, want);
            end
        end
    endtask

    task automatic test_multi_hot();
        in_vec   = 8'b0000_1100;
        in_valid = 1'b1;
        tick();
        vectors++;
        if (obs_msb !== 6'b1_011_01) begin
            miscompares++;
            $display("[TB] FAIL multi_hot_msb got %b want 101101", obs_msb);
        end
        vectors++;
        if (obs_lsb !== 6'b1_010_01) begin
            miscompares++;
            $display("[TB] FAIL multi_hot_lsb got %b want 101001", obs_lsb);
        end
    endtask

    task automatic test_all_zero();
        in_vec   = 8'b0000_0000;
        in_valid = 1'b1;
        tick();
        vectors++;
        if (obs_msb !== 6'b1_000_10 || obs_lsb !== 6'b1_000_10) begin
            miscompares++;
            $display("[TB] FAIL all_zero got msb=%b lsb=%b want 100010", obs_msb, obs_lsb);
        end
    endtask

    task automatic test_valid_gating();
        in_vec   = 8'b0000_1100;
        in_valid = 1'b0;
        tick();
        vectors++;
        if (obs_msb !== 6'b0_011_00 || obs_lsb !== 6'b0_010_00) begin
            miscompares++;
            $display("[TB] FAIL valid_gating got msb=%b lsb=%b want 001100/001000", obs_msb, obs_lsb);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        in_vec   = 8'b1000_0000;
        tick();
        vectors++;
        if (obs_msb !== 6'b1_111_00 || obs_lsb !== 6'b1_111_00) begin
            miscompares++;
            $display("[TB] FAIL b2b_top_bit got msb=%b lsb=%b want 111100", obs_msb, obs_lsb);
        end
        in_vec = 8'b0000_0000;
        tick();
        vectors++;
        if (obs_msb !== 6'b1_000_10 || obs_lsb !== 6'b1_000_10) begin
            miscompares++;
            $display("[TB] FAIL b2b_zero got msb=%b lsb=%b want 100010", obs_msb, obs_lsb);
        end
        in_vec = 8'b1111_1111;
        tick();
        vectors++;
        if (obs_msb !== 6'b1_111_01 || obs_lsb !== 6'b1_000_01) begin
            miscompares++;
            $display("[TB] FAIL b2b_all_ones got msb=%b lsb=%b want 111101/100001", obs_msb, obs_lsb);
        end
        in_vec   = 8'b0010_0000;
        in_valid = 1'b1;
        tick();
        vectors++;
        if (obs_msb !== 6'b1_101_00 || obs_lsb !== 6'b1_101_00) begin
            miscompares++;
            $display("[TB] FAIL b2b_flags_clear got msb=%b lsb=%b want 110100", obs_msb, obs_lsb);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_one_hot_sweep();
        test_multi_hot();
        test_all_zero();
        test_valid_gating();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/encoder_8to3.md
Name: encoder_8to3

Overview:
- Registered 8-to-3 binary encoder. Converts an 8-bit one-hot input vector to its 3-bit bit index.
- Flags illegal inputs: all-zero, or more than one bit set.
- Sits as a small pipeline stage between request/select logic and downstream index consumers.
- Output is registered, one cycle of latency, with a valid qualifier.

Parameters:
- IN_W, 8, input vector width; must be a power of two ≥ 2.
- OUT_W, $clog2(IN_W) = 3, encoded index width; derived, not overridden.
- PRIO_MSB, 1, multi-hot resolution: 1 = highest set bit wins, 0 = lowest set bit wins.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in  input  IN_W  one-hot input vector; bit i set encodes index i.
- in_valid  input  1  qualifies in; sampled every rising edge.
- out  output  OUT_W  registered encoded index.
- out_valid  output  1  registered copy of in_valid.
- zero  output  1  registered: in had no bit set while in_valid=1.
- multi  output  1  registered: in had ≥2 bits set while in_valid=1.

Behaviour:
- Reset (rst=1, asynchronous, immediate regardless of clk): out=0, out_valid=0, zero=0, multi=0. Held while rst=1. First capture occurs on the first rising clk edge after rst deasserts.
- Latency: exactly 1 cycle. Values present on in/in_valid at rising edge N appear on the outputs after edge N. Fully pipelined; a new input is accepted every cycle. No backpressure.
- One-hot input: out = index of the set bit.
  - 8'b00000001 -> 3'b000, 8'b00000010 -> 3'b001, and so on through 8'b10000000 -> 3'b111.
  - zero=0, multi=0.
- Multi-hot input:
  - PRIO_MSB=1: out = index of the highest set bit.
  - PRIO_MSB=0: out = index of the lowest set bit.
  - multi=1, zero=0.
- All-zero input: out=0, zero=1, multi=0.
- zero and multi are mutually exclusive and are never both 1.
- in_valid=0 at an edge: out_valid=0, zero=0, multi=0. out still registers the encoding of the current in; downstream must ignore it.
- No X propagation: out is always a defined value for any known in.
- Reset mid-stream: the in-flight result is discarded. out_valid is low in the first post-reset cycle unless in_valid was high at that first edge.

Decomposition:
- Package encoder_pkg:
  - localparam ENC_IN_W = 8
  - localparam ENC_OUT_W = 3
  - typedef enc_in_t (logic [7:0])
  - typedef enc_idx_t (logic [2:0])
- One combinational sub-module, encoder_8to3_core (in -> idx, zero, multi, parameterised by PRIO_MSB). It is built as a loop-based priority scan plus a popcount-≥2 detector.
- The top module instantiates the core and adds the reset-able output register stage.

Test Plan:
- Reset: assert rst mid-cycle with out_valid=1 -> all outputs 0 immediately, before the next clk edge. Deassert, apply in=8'b00000100, in_valid=1 -> next cycle out=3'b010, out_valid=1.
- One-hot sweep: apply 8'b00000001 through 8'b10000000 on consecutive cycles, in_valid=1 -> outputs one cycle later are 000,001,...,111 in order, with zero=0 and multi=0 throughout.
- Multi-hot: in=8'b00001100 -> out=3'b011, multi=1 (PRIO_MSB=1); the same input with PRIO_MSB=0 -> out=3'b010, multi=1.
- All-zero: in=8'b00000000, in_valid=1 -> out=3'b000, zero=1, multi=0, out_valid=1.
- Valid gating: in=8'b00001100, in_valid=0 -> out_valid=0, zero=0, multi=0.
- Back-to-back mix: 8'b10000000, 8'b00000000, 8'b11111111 on successive cycles -> (111,zero=0,multi=0), (000,zero=1), (111,multi=1). Confirms 1-cycle latency and no stale flags.
